// File: rtl/if_fetch_queue_if.sv
// rtl/if_fetch_queue_if.sv - fetch queue bundle: redirect, instruction memory and decode handshake
interface if_fetch_queue_if;
    logic        redirect;
    logic [31:0] redirect_pc;
    logic        imem_req;
    logic [31:0] imem_addr;
    logic        imem_ack;
    logic [31:0] imem_rdata;
    logic [31:0] inst;
    logic [31:0] inst_pc;
    logic        inst_valid;
    logic        inst_ready;

    // fetch queue side
    modport master (
        input  redirect, redirect_pc, imem_ack, imem_rdata, inst_ready,
        output imem_req, imem_addr, inst, inst_pc, inst_valid
    );

    // memory / execute / decode side
    modport slave (
        output redirect, redirect_pc, imem_ack, imem_rdata, inst_ready,
        input  imem_req, imem_addr, inst, inst_pc, inst_valid
    );
endinterface

// File: rtl/if_fetch_queue.sv
// rtl/if_fetch_queue.sv - instruction fetch FSM with {pc, word} FIFO feeding decode
module if_fetch_queue #(
    parameter int          DEPTH    = 4,
    parameter logic [31:0] RESET_PC = 32'h0000_0000,
    parameter logic [31:0] NOP_INST = 32'h0000_0013
) (
    input logic            clk,
    input logic            rst,
    if_fetch_queue_if.master bus
);
    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;
    localparam logic [CW-1:0] FULL = CW'(DEPTH);

    typedef enum logic [1:0] {IDLE, REQ, DISCARD} state_t;

    state_t          r_state;
    logic [31:0]     r_fetch_pc;
    logic [31:0]     r_pending_pc;
    logic            r_imem_req;
    logic [CW-1:0]   r_count;
    logic [AW-1:0]   r_wptr;
    logic [AW-1:0]   r_rptr;
    logic [31:0]     r_pc_mem   [DEPTH];
    logic [31:0]     r_word_mem [DEPTH];

    logic [31:0]     w_redirect_pc;
    logic            w_push;
    logic            w_pop;
    logic            w_valid;
    logic [CW-1:0]   w_count_next;

    assign w_redirect_pc = bus.redirect_pc & ~32'h0000_0003;
    assign w_valid       = (r_count != '0);
    assign w_pop         = w_valid && bus.inst_ready;
    // Data returned while a redirect is live belongs to the wrong path.
    assign w_push        = (r_state == REQ) && bus.imem_ack && !bus.redirect;

    // Occupancy after this cycle's push/pop, ignoring flush.
    always_comb begin
        w_count_next = r_count;
        if (w_push && !w_pop) begin
            w_count_next = r_count + CW'(1);
        end else if (!w_push && w_pop) begin
            w_count_next = r_count - CW'(1);
        end
    end

    // Fetch FSM; imem_addr is fetch_pc itself, which stays put through DISCARD.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state      <= IDLE;
            r_fetch_pc   <= RESET_PC;
            r_pending_pc <= 32'h0;
            r_imem_req   <= 1'b0;
        end else begin
            case (r_state)
                IDLE: begin
                    if (bus.redirect) begin
                        r_fetch_pc <= w_redirect_pc;
                        r_state    <= REQ;
                        r_imem_req <= 1'b1;
                    end else if (r_count < FULL) begin
                        r_state    <= REQ;
                        r_imem_req <= 1'b1;
                    end
                end
                REQ: begin
                    if (bus.imem_ack) begin
                        if (bus.redirect) begin
                            r_fetch_pc <= w_redirect_pc;
                            r_state    <= REQ;
                            r_imem_req <= 1'b1;
                        end else begin
                            r_fetch_pc <= r_fetch_pc + 32'd4;
                            if (w_count_next < FULL) begin
                                r_state    <= REQ;
                                r_imem_req <= 1'b1;
                            end else begin
                                r_state    <= IDLE;
                                r_imem_req <= 1'b0;
                            end
                        end
                    end else if (bus.redirect) begin
                        // The outstanding request must complete before restarting.
                        r_pending_pc <= w_redirect_pc;
                        r_state      <= DISCARD;
                    end
                end
                DISCARD: begin
                    if (bus.imem_ack) begin
                        r_fetch_pc <= bus.redirect ? w_redirect_pc : r_pending_pc;
                        r_state    <= REQ;
                    end else if (bus.redirect) begin
                        r_pending_pc <= w_redirect_pc;
                    end
                end
                default: begin
                    r_state    <= IDLE;
                    r_imem_req <= 1'b0;
                end
            endcase
        end
    end

    // FIFO pointers and occupancy; a redirect flushes everything, beating a same-cycle pop.
    always_ff @(posedge clk) begin
        if (rst || bus.redirect) begin
            r_wptr  <= '0;
            r_rptr  <= '0;
            r_count <= '0;
        end else begin
            if (w_push) begin
                r_wptr <= r_wptr + AW'(1);
            end
            if (w_pop) begin
                r_rptr <= r_rptr + AW'(1);
            end
            r_count <= w_count_next;
        end
    end

    // FIFO storage; contents are only observed through the valid-gated head mux.
    always_ff @(posedge clk) begin
        if (w_push) begin
            r_pc_mem[r_wptr]   <= r_fetch_pc;
            r_word_mem[r_wptr] <= bus.imem_rdata;
        end
    end

    assign bus.imem_req   = r_imem_req;
    assign bus.imem_addr  = r_fetch_pc;
    assign bus.inst_valid = w_valid;
    assign bus.inst       = w_valid ? r_word_mem[r_rptr] : NOP_INST;
    assign bus.inst_pc    = w_valid ? r_pc_mem[r_rptr] : 32'h0;
endmodule
